// File: rtl/nco_pkg.sv
// Shared defaults and state encoding for the NCO FCW sweep generator.
package nco_pkg;

    localparam int unsigned FCW_W_DEF   = 32;
    localparam int unsigned DWELL_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable dwell down-counter; expired flags the last cycle of a dwell.
module nco_dwell_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/nco_fcw_sweep.sv
// Stepped FCW sweep generator feeding the NCO tuning input.
// Define NCO_SWEEP_TRI_EN for triangular looping (adds the DOWN state); default is sawtooth.
module nco_fcw_sweep
    import nco_pkg::*;
#(
    parameter int unsigned FCW_W   = FCW_W_DEF,
    parameter int unsigned DWELL_W = DWELL_W_DEF
) (
    input  logic               clk_top,
    input  logic               rst_top,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [FCW_W-1:0]   cfg_start,
    input  logic [FCW_W-1:0]   cfg_stop,
    input  logic [FCW_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_loop,
    input  logic               abort,
    output logic [FCW_W-1:0]   fcw_out,
    output logic               busy,
    output logic               done
);

    state_t             state_q;
    state_t             state_nxt;
    logic [FCW_W-1:0]   start_q;
    logic [FCW_W-1:0]   stop_q;
    logic [FCW_W-1:0]   step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               loop_q;

    logic [FCW_W-1:0]   fcw_nxt;
    logic               load_c;
    logic [DWELL_W-1:0] load_val_c;
    logic               expired_c;
    logic               accept_c;
    logic [FCW_W:0]     sum_c;
    logic [FCW_W-1:0]   up_val_c;

    assign cfg_ready = (state_q == ST_IDLE);
    assign accept_c  = cfg_valid & cfg_ready;

    // Ascending step saturates at stop, including carry out of the tuning word.
    assign sum_c    = {1'b0, fcw_out} + {1'b0, step_q};
    assign up_val_c = (sum_c[FCW_W] || (sum_c[FCW_W-1:0] > stop_q)) ? stop_q : sum_c[FCW_W-1:0];

`ifdef NCO_SWEEP_TRI_EN
    logic [FCW_W:0]   diff_c;
    logic [FCW_W-1:0] dn_val_c;

    // Descending step saturates at start, including borrow.
    assign diff_c   = {1'b0, fcw_out} - {1'b0, step_q};
    assign dn_val_c = (diff_c[FCW_W] || (diff_c[FCW_W-1:0] < start_q)) ? start_q : diff_c[FCW_W-1:0];
`endif

    nco_dwell_timer #(
        .W (DWELL_W)
    ) u_dwell (
        .clk      (clk_top),
        .rst      (rst_top),
        .load     (load_c),
        .load_val (load_val_c),
        .expired  (expired_c)
    );

    always_comb begin
        state_nxt  = state_q;
        fcw_nxt    = fcw_out;
        load_c     = 1'b0;
        load_val_c = dwell_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_nxt  = ST_UP;
                    fcw_nxt    = cfg_start;
                    load_c     = 1'b1;
                    load_val_c = cfg_dwell;
                end
            end
            ST_UP: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (expired_c) begin
                    if (fcw_out == stop_q) begin
                        if (!loop_q) begin
                            state_nxt = ST_DONE;
                        end else begin
`ifdef NCO_SWEEP_TRI_EN
                            state_nxt = ST_DOWN;
                            fcw_nxt   = dn_val_c;
`else
                            fcw_nxt   = start_q;
`endif
                            load_c    = 1'b1;
                        end
                    end else begin
                        fcw_nxt = up_val_c;
                        load_c  = 1'b1;
                    end
                end
            end
`ifdef NCO_SWEEP_TRI_EN
            ST_DOWN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (expired_c) begin
                    if (fcw_out == start_q) begin
                        state_nxt = ST_UP;
                        fcw_nxt   = up_val_c;
                    end else begin
                        fcw_nxt   = dn_val_c;
                    end
                    load_c = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_top) begin
        if (rst_top) begin
            state_q <= ST_IDLE;
            fcw_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= FCW_W'(1);
            dwell_q <= '0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            fcw_out <= fcw_nxt;
            busy    <= (state_nxt != ST_IDLE);
            done    <= (state_nxt == ST_DONE);
            // An inverted range collapses to a single-value sweep; step 0 acts as 1.
            if (accept_c) begin
                start_q <= cfg_start;
                stop_q  <= (cfg_start > cfg_stop) ? cfg_start : cfg_stop;
                step_q  <= (cfg_step == '0) ? FCW_W'(1) : cfg_step;
                dwell_q <= cfg_dwell;
                loop_q  <= cfg_loop;
            end
        end
    end

endmodule
